cache_way_select: RTL

// 4-way set-associative tag lookup and victim controller; sits directly upstream of cache_LRU.

---
 rtl/cache_pkg.sv | 35 +++
 rtl/cache_way_select_if.sv | 40 ++++
 rtl/cache_tag_ram.sv | 29 ++
 rtl/cache_way_select.sv | 125 ++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and defaults for the 4-way tag lookup / victim controller.
// Holds the FSM encoding, the registered response bundle and a way-encoding helper.
package cache_pkg;

   localparam int SET_BITS_DEF = 9;
   localparam int TAG_BITS_DEF = 16;
   localparam int WAYS         = 4;
   localparam int WAY_BITS     = 2;

   typedef enum logic [2:0] {
      ST_INIT,
      ST_IDLE,
      ST_COMPARE,
      ST_FILL,
      ST_WRITE
   } cache_state_t;

   typedef struct packed {
      logic [TAG_BITS_DEF-1:0] tag;
      logic [SET_BITS_DEF-1:0] set;
   } cache_req_t;

   typedef struct packed {
      logic                valid;
      logic [WAY_BITS-1:0] way;
      logic                was_hit;
   } cache_resp_t;

   function automatic logic [WAY_BITS-1:0] way_enc(input logic [WAYS-1:0] v);
      way_enc = '0;
      for (int i = 0; i < WAYS; i++)
         if (v[i]) way_enc = WAY_BITS'(i);
   endfunction

endpackage

// File: rtl/cache_way_select_if.sv
// Request/response, fill and cache_LRU signals of the way-select block.
// The slave modport is the block itself; master is the surrounding system.
interface cache_way_select_if
   import cache_pkg::*;
#(
   parameter int SET_BITS = SET_BITS_DEF,
   parameter int TAG_BITS = TAG_BITS_DEF
);
   localparam int ADDR_BITS = SET_BITS + TAG_BITS;

   logic                 req_valid;
   logic                 req_ready;
   logic [ADDR_BITS-1:0] req_addr;
   logic                 resp_valid;
   logic [WAY_BITS-1:0]  resp_way;
   logic                 resp_was_hit;
   logic                 fill_req;
   logic [ADDR_BITS-1:0] fill_addr;
   logic [WAY_BITS-1:0]  fill_way;
   logic                 fill_done;
   logic [SET_BITS-1:0]  lru_addr;
   logic [WAY_BITS-1:0]  lru_used_index;
   logic                 lru_enable_write;
   logic [WAY_BITS-1:0]  lru_least_used_index;

   modport master (
      output req_valid, req_addr, fill_done, lru_least_used_index,
      input  req_ready, resp_valid, resp_way, resp_was_hit,
             fill_req, fill_addr, fill_way,
             lru_addr, lru_used_index, lru_enable_write
   );

   modport slave (
      input  req_valid, req_addr, fill_done, lru_least_used_index,
      output req_ready, resp_valid, resp_way, resp_was_hit,
             fill_req, fill_addr, fill_way,
             lru_addr, lru_used_index, lru_enable_write
   );

endinterface

// File: rtl/cache_tag_ram.sv
// Tag store: one entry {valid, tag} per way per set, registered read, per-way write.
// No reset; the controller's INIT sweep clears the valid bits.
module cache_tag_ram
   import cache_pkg::*;
#(
   parameter int SET_BITS = SET_BITS_DEF,
   parameter int TAG_BITS = TAG_BITS_DEF
) (
   input  logic                          main_clk,
   input  logic [SET_BITS-1:0]           rd_addr,
   output logic [WAYS-1:0][TAG_BITS:0]   rd_data,
   input  logic [SET_BITS-1:0]           wr_addr,
   input  logic [WAYS-1:0]               wr_en,
   input  logic [TAG_BITS:0]             wr_data
);

   for (genvar w = 0; w < WAYS; w++) begin : g_way
      logic [TAG_BITS:0] mem [2**SET_BITS];
      logic [TAG_BITS:0] rd_q;

      always_ff @(posedge main_clk) begin
         if (wr_en[w]) mem[wr_addr] <= wr_data;
         rd_q <= mem[rd_addr];
      end

      assign rd_data[w] = rd_q;
   end

endmodule

// File: rtl/cache_way_select.sv
// 4-way tag lookup and victim controller feeding cache_LRU.
// One access at a time: lookup, then on a miss fill the LRU victim and write its tag.
module cache_way_select
   import cache_pkg::*;
#(
   parameter int SET_BITS = SET_BITS_DEF,
   parameter int TAG_BITS = TAG_BITS_DEF
) (
   input  logic              main_clk,
   input  logic              rst,
   cache_way_select_if.slave bus
);

   localparam int ADDR_BITS = SET_BITS + TAG_BITS;

   cache_state_t                state, state_nxt;
   logic [SET_BITS-1:0]         init_cnt;
   logic [ADDR_BITS-1:0]        addr_q;
   logic [WAY_BITS-1:0]         victim_q;
   cache_resp_t                 resp_q, resp_nxt;

   logic [SET_BITS-1:0]         set_q, req_set, rd_addr, wr_addr;
   logic [TAG_BITS-1:0]         tag_q;
   logic [WAYS-1:0][TAG_BITS:0] rd_data;
   logic [WAYS-1:0]             wr_en, hit_vec;
   logic [TAG_BITS:0]           wr_data;
   logic                        hit, accept, lru_we;
   logic [WAY_BITS-1:0]         hit_way, lru_idx;

   assign set_q   = addr_q[SET_BITS-1:0];
   assign tag_q   = addr_q[ADDR_BITS-1:SET_BITS];
   assign req_set = bus.req_addr[SET_BITS-1:0];
   assign accept  = (state == ST_IDLE) && bus.req_valid;
   // The RAM is addressed with the live request in IDLE so its output lands in COMPARE.
   assign rd_addr = (state == ST_IDLE) ? req_set : set_q;

   cache_tag_ram #(.SET_BITS(SET_BITS), .TAG_BITS(TAG_BITS)) u_tag_ram (
      .main_clk (main_clk),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .wr_addr  (wr_addr),
      .wr_en    (wr_en),
      .wr_data  (wr_data)
   );

   always_comb begin
      for (int w = 0; w < WAYS; w++)
         hit_vec[w] = rd_data[w][TAG_BITS] && (rd_data[w][TAG_BITS-1:0] == tag_q);
   end
   assign hit     = |hit_vec;
   assign hit_way = way_enc(hit_vec);

   always_ff @(posedge main_clk or posedge rst) begin
      if (rst) begin
         state    <= ST_INIT;
         init_cnt <= '0;
         addr_q   <= '0;
         victim_q <= '0;
         resp_q   <= '0;
      end else begin
         state  <= state_nxt;
         resp_q <= resp_nxt;
         if (state == ST_INIT) init_cnt <= init_cnt + 1'b1;
         if (accept) addr_q <= bus.req_addr;
         if (state == ST_COMPARE && !hit) victim_q <= bus.lru_least_used_index;
      end
   end

   always_comb begin
      state_nxt = state;
      resp_nxt  = '0;
      wr_en     = '0;
      wr_addr   = set_q;
      wr_data   = {1'b1, tag_q};
      lru_we    = 1'b0;
      lru_idx   = '0;
      case (state)
         ST_INIT: begin
            wr_en   = '1;
            wr_addr = init_cnt;
            wr_data = '0;
            if (init_cnt == '1) state_nxt = ST_IDLE;
         end
         ST_IDLE: begin
            if (bus.req_valid) state_nxt = ST_COMPARE;
         end
         ST_COMPARE: begin
            lru_we = 1'b1;
            if (hit) begin
               lru_idx   = hit_way;
               resp_nxt  = '{valid: 1'b1, way: hit_way, was_hit: 1'b1};
               state_nxt = ST_IDLE;
            end else begin
               lru_idx   = bus.lru_least_used_index;
               state_nxt = ST_FILL;
            end
         end
         ST_FILL: begin
            if (bus.fill_done) state_nxt = ST_WRITE;
         end
         ST_WRITE: begin
            wr_en[victim_q] = 1'b1;
            resp_nxt        = '{valid: 1'b1, way: victim_q, was_hit: 1'b0};
            state_nxt       = ST_IDLE;
         end
         default: state_nxt = ST_INIT;
      endcase
   end

   assign bus.req_ready        = (state == ST_IDLE);
   assign bus.resp_valid       = resp_q.valid;
   assign bus.resp_way         = resp_q.way;
   assign bus.resp_was_hit     = resp_q.was_hit;
   assign bus.fill_req         = (state == ST_FILL) && !bus.fill_done;
   assign bus.fill_addr        = addr_q;
   assign bus.fill_way         = victim_q;
   assign bus.lru_addr         = (state == ST_IDLE) ? req_set :
                                 (state == ST_INIT) ? '0 : set_q;
   assign bus.lru_enable_write = lru_we;
   assign bus.lru_used_index   = lru_idx;

   a_single_hit: assert property (@(posedge main_clk) disable iff (rst)
      (state == ST_COMPARE) |-> $onehot0(hit_vec));

endmodule
